// File: rtl/gate_send_pkg.sv
// Shared route-word layout, capability entry and FSM state types. Both the
// send and receive gates decode route words through these definitions.
package gate_send_pkg;

    localparam int ROUTE_W        = 14;
    localparam int ROUTE_UL_LSB   = 6;
    localparam int ROUTE_UL_W     = 4;
    localparam int ROUTE_PORT_LSB = 0;
    localparam int ROUTE_PORT_W   = 2;

    typedef struct packed {
        logic                  en;
        logic [ROUTE_UL_W-1:0] id;
    } gate_cap_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SEND,
        ST_DROP
    } gate_state_e;

    // Build a route word: only the UL id and port fields are non-zero.
    function automatic logic [ROUTE_W-1:0] make_route(
        input logic [ROUTE_UL_W-1:0]   ul,
        input logic [ROUTE_PORT_W-1:0] port
    );
        logic [ROUTE_W-1:0] r;
        r = '0;
        r[ROUTE_UL_LSB +: ROUTE_UL_W]     = ul;
        r[ROUTE_PORT_LSB +: ROUTE_PORT_W] = port;
        return r;
    endfunction

endpackage

// File: rtl/gate_send_if.sv
// Host-control, request and route-out signals of the send gate.
interface gate_send_if #(
    parameter int CNT_BITS = 16
);
    import gate_send_pkg::*;

    logic [ROUTE_W-1:0]      route_ctrl;
    logic                    route_ctrl_valid;
    logic                    req_valid;
    logic                    req_ready;
    logic [ROUTE_UL_W-1:0]   req_ul_id;
    logic [ROUTE_PORT_W-1:0] req_port;
    logic [ROUTE_W-1:0]      route_out;
    logic                    route_out_valid;
    logic                    route_out_ready;
    logic                    drop_pulse;
    logic [CNT_BITS-1:0]     drop_cnt;

    modport master (
        output route_ctrl, route_ctrl_valid, req_valid, req_ul_id, req_port, route_out_ready,
        input  req_ready, route_out, route_out_valid, drop_pulse, drop_cnt
    );

    modport slave (
        input  route_ctrl, route_ctrl_valid, req_valid, req_ul_id, req_port, route_out_ready,
        output req_ready, route_out, route_out_valid, drop_pulse, drop_cnt
    );

endinterface

// File: rtl/gate_cap_table.sv
// Per-port capability table: one write port, one combinational read port.
// A read in the same cycle as a write to that entry returns the old value.
module gate_cap_table
    import gate_send_pkg::*;
#(
    parameter int N_DESTS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ROUTE_PORT_W-1:0] wr_idx,
    input  logic [ROUTE_UL_W-1:0]   wr_id,
    input  logic [ROUTE_PORT_W-1:0] rd_idx,
    output gate_cap_t               rd_cap
);

    gate_cap_t tbl [N_DESTS];

    // Write/overwrite an entry; indices beyond the table match nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DESTS; i++) tbl[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_DESTS; i++)
                if (wr_idx == i[ROUTE_PORT_W-1:0]) tbl[i] <= '{en: 1'b1, id: wr_id};
        end
    end

    // Read mux; an out-of-range index reads as a disabled entry.
    always_comb begin
        rd_cap = '0;
        for (int i = 0; i < N_DESTS; i++)
            if (rd_idx == i[ROUTE_PORT_W-1:0]) rd_cap = tbl[i];
    end

endmodule

// File: rtl/gate_send.sv
// Transmit-side routing gate: checks each send request against the
// capability table, forwards a route word when permitted, counts denials.
module gate_send
    import gate_send_pkg::*;
#(
    parameter int N_DESTS  = 4,
    parameter int CNT_BITS = 16
) (
    input logic        aclk,
    input logic        areset,
    gate_send_if.slave bus
);

    gate_state_e             state, state_n;
    logic                    ready_q;
    logic [ROUTE_UL_W-1:0]   req_ul_q;
    logic [ROUTE_PORT_W-1:0] req_port_q;
    logic [ROUTE_W-1:0]      route_q;
    logic                    route_vld_q;
    logic [CNT_BITS-1:0]     cnt_q;
    gate_cap_t               cap;
    logic                    permit;
    logic                    accept;
    logic                    unused_ctrl_bits;

    assign unused_ctrl_bits = ^{bus.route_ctrl[ROUTE_W-1:ROUTE_UL_LSB+ROUTE_UL_W],
                                bus.route_ctrl[ROUTE_UL_LSB-1:ROUTE_PORT_W]};

    gate_cap_table #(.N_DESTS(N_DESTS)) u_table (
        .clk    (aclk),
        .rst    (areset),
        .wr_en  (bus.route_ctrl_valid),
        .wr_idx (bus.route_ctrl[ROUTE_PORT_LSB +: ROUTE_PORT_W]),
        .wr_id  (bus.route_ctrl[ROUTE_UL_LSB +: ROUTE_UL_W]),
        .rd_idx (req_port_q),
        .rd_cap (cap)
    );

    assign accept = (state == ST_IDLE) && ready_q && bus.req_valid;
    assign permit = (int'(req_port_q) < N_DESTS) && cap.en && (cap.id == req_ul_q);

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (accept) state_n = ST_CHECK;
            ST_CHECK: state_n = permit ? ST_SEND : ST_DROP;
            ST_SEND:  if (bus.route_out_ready) state_n = ST_IDLE;
            ST_DROP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // State register; ready is registered so it stays low through reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == ST_IDLE);
        end
    end

    // Capture the accepted request for the table check.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            req_ul_q   <= '0;
            req_port_q <= '0;
        end else if (accept) begin
            req_ul_q   <= bus.req_ul_id;
            req_port_q <= bus.req_port;
        end
    end

    // Route word held from a permitted check until the downstream handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            route_q     <= '0;
            route_vld_q <= 1'b0;
        end else if (state == ST_CHECK && permit) begin
            route_q     <= make_route(req_ul_q, req_port_q);
            route_vld_q <= 1'b1;
        end else if (state == ST_SEND && bus.route_out_ready) begin
            route_q     <= '0;
            route_vld_q <= 1'b0;
        end
    end

    // Saturating drop counter, one step per denied request.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                                cnt_q <= '0;
        else if (state == ST_DROP && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end

    assign bus.req_ready       = ready_q;
    assign bus.route_out       = route_q;
    assign bus.route_out_valid = route_vld_q;
    assign bus.drop_pulse      = (state == ST_DROP);
    assign bus.drop_cnt        = cnt_q;

endmodule

// File: tb/tb_gate_send.sv
// Directed bench for gate_send: main instance (4 ports, 16-bit counter) and a
// small instance (3 ports, 2-bit counter) for table-range and saturation cases.
module tb_gate_send;

    logic aclk = 1'b0;
    logic areset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 aclk = ~aclk;

    gate_send_if #(.CNT_BITS(16)) m ();
    gate_send_if #(.CNT_BITS(2))  s ();

    gate_send #(.N_DESTS(4), .CNT_BITS(16)) u_dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (m.slave)
    );

    gate_send #(.N_DESTS(3), .CNT_BITS(2)) u_sat (
        .aclk   (aclk),
        .areset (areset),
        .bus    (s.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr_ctrl(input logic [3:0] id, input logic [1:0] port);
        m.route_ctrl       = {4'b0, id, 4'b0, port};
        m.route_ctrl_valid = 1'b1;
        step();
        m.route_ctrl_valid = 1'b0;
    endtask

    // Present a request once ready and let it be accepted; returns in CHECK.
    task automatic req(input logic [3:0] ul, input logic [1:0] port);
        int n;
        n = 0;
        while (!m.req_ready && n < 20) begin
            step();
            n++;
        end
        chk("req_ready_wait", {31'b0, m.req_ready}, 32'd1);
        m.req_ul_id = ul;
        m.req_port  = port;
        m.req_valid = 1'b1;
        step();
        m.req_valid = 1'b0;
    endtask

    initial begin
        int n;
        areset = 1'b1;
        m.route_ctrl = '0; m.route_ctrl_valid = 1'b0; m.req_valid = 1'b0;
        m.req_ul_id = '0; m.req_port = '0; m.route_out_ready = 1'b0;
        s.route_ctrl = '0; s.route_ctrl_valid = 1'b0; s.req_valid = 1'b0;
        s.req_ul_id = '0; s.req_port = '0; s.route_out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", {31'b0, m.route_out_valid}, 32'd0);
        chk("rst_route", {18'b0, m.route_out}, 32'd0);
        chk("rst_pulse", {31'b0, m.drop_pulse}, 32'd0);
        chk("rst_cnt",   {16'b0, m.drop_cnt}, 32'd0);
        chk("rst_ready", {31'b0, m.req_ready}, 32'd0);
        areset = 1'b0;
        step();
        chk("post_rst_ready", {31'b0, m.req_ready}, 32'd1);

        // Permitted request, immediate downstream acceptance.
        wr_ctrl(4'd5, 2'd2);
        req(4'd5, 2'd2);
        chk("t1_check_valid", {31'b0, m.route_out_valid}, 32'd0);
        chk("t1_check_ready", {31'b0, m.req_ready}, 32'd0);
        step();
        chk("t1_valid", {31'b0, m.route_out_valid}, 32'd1);
        chk("t1_route", {18'b0, m.route_out}, 32'h142);
        m.route_out_ready = 1'b1;
        step();
        m.route_out_ready = 1'b0;
        chk("t1_hs_valid", {31'b0, m.route_out_valid}, 32'd0);
        chk("t1_hs_route", {18'b0, m.route_out}, 32'd0);
        chk("t1_idle_ready", {31'b0, m.req_ready}, 32'd1);
        chk("t1_cnt", {16'b0, m.drop_cnt}, 32'd0);

        // Wrong UL id on programmed port.
        req(4'd3, 2'd2);
        step();
        chk("t2_pulse", {31'b0, m.drop_pulse}, 32'd1);
        chk("t2_valid", {31'b0, m.route_out_valid}, 32'd0);
        step();
        chk("t2_pulse_end", {31'b0, m.drop_pulse}, 32'd0);
        chk("t2_cnt", {16'b0, m.drop_cnt}, 32'd1);

        // Unprogrammed port with UL 0 matches reset id but en=0.
        req(4'd0, 2'd1);
        step();
        chk("t3_pulse", {31'b0, m.drop_pulse}, 32'd1);
        step();
        chk("t3_cnt", {16'b0, m.drop_cnt}, 32'd2);

        // Backpressure: word held stable for 5 cycles.
        req(4'd5, 2'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'b0, m.route_out_valid}, 32'd1);
            chk("t4_hold_route", {18'b0, m.route_out}, 32'h142);
            chk("t4_hold_ready", {31'b0, m.req_ready}, 32'd0);
            step();
        end
        m.route_out_ready = 1'b1;
        step();
        m.route_out_ready = 1'b0;
        chk("t4_hs_valid", {31'b0, m.route_out_valid}, 32'd0);
        chk("t4_idle_ready", {31'b0, m.req_ready}, 32'd1);

        // Table write coinciding with CHECK: old entry decides.
        req(4'd5, 2'd2);
        m.route_ctrl       = {4'b0, 4'd7, 4'b0, 2'd2};
        m.route_ctrl_valid = 1'b1;
        step();
        m.route_ctrl_valid = 1'b0;
        chk("t5_old_valid", {31'b0, m.route_out_valid}, 32'd1);
        chk("t5_old_route", {18'b0, m.route_out}, 32'h142);
        m.route_out_ready = 1'b1;
        step();
        m.route_out_ready = 1'b0;
        req(4'd5, 2'd2);
        step();
        chk("t5_new_pulse", {31'b0, m.drop_pulse}, 32'd1);
        step();
        chk("t5_new_cnt", {16'b0, m.drop_cnt}, 32'd3);

        // Reset during SEND clears outputs at once and empties the table.
        req(4'd7, 2'd2);
        step();
        chk("t6_pre_valid", {31'b0, m.route_out_valid}, 32'd1);
        chk("t6_pre_route", {18'b0, m.route_out}, 32'h1C2);
        areset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'b0, m.route_out_valid}, 32'd0);
        chk("t6_rst_route", {18'b0, m.route_out}, 32'd0);
        step();
        areset = 1'b0;
        step();
        chk("t6_cnt", {16'b0, m.drop_cnt}, 32'd0);
        chk("t6_pulse", {31'b0, m.drop_pulse}, 32'd0);
        req(4'd7, 2'd2);
        step();
        chk("t6_empty_pulse", {31'b0, m.drop_pulse}, 32'd1);
        step();
        chk("t6_empty_cnt", {16'b0, m.drop_cnt}, 32'd1);

        // Small instance: write to port 3 is out of range, requests to it
        // are denied, and the 2-bit counter saturates at 3.
        s.route_ctrl       = {4'b0, 4'd0, 4'b0, 2'd3};
        s.route_ctrl_valid = 1'b1;
        step();
        s.route_ctrl_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!s.req_ready && n < 20) begin
                step();
                n++;
            end
            chk("sat_ready_wait", {31'b0, s.req_ready}, 32'd1);
            s.req_ul_id = 4'd0;
            s.req_port  = 2'd3;
            s.req_valid = 1'b1;
            step();
            s.req_valid = 1'b0;
            step();
            chk("sat_pulse", {31'b0, s.drop_pulse}, 32'd1);
            chk("sat_valid", {31'b0, s.route_out_valid}, 32'd0);
            step();
            chk("sat_cnt", {30'b0, s.drop_cnt}, (k < 2) ? k + 1 : 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_send.md
Name: gate_send

Overview:
- Transmit-side routing gate for the VIU network path; counterpart of the receive-side gate.
- Holds a host-programmed per-port send-capability table.
- Accepts user-logic send requests (UL id, destination port) and checks each against the table.
- Emits a formatted 14-bit route word for permitted requests; drops and counts denied ones.

Parameters:
- N_DESTS, 4, number of destination ports / table entries (max 4; port id is 2 bits)
- CNT_BITS, 16, width of the saturating drop counter

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- route_ctrl  in  14  host capability word: [9:6] permitted sender UL id, [1:0] port id, other bits ignored
- route_ctrl_valid  in  1  write strobe for route_ctrl
- req_valid  in  1  send request valid
- req_ready  out  1  request accepted this cycle
- req_ul_id  in  4  requesting UL id
- req_port  in  2  requested destination port
- route_out  out  14  route word: [13:10]=0, [9:6]=UL id, [5:2]=0, [1:0]=port
- route_out_valid  out  1  route word valid
- route_out_ready  in  1  downstream accepts route word
- drop_pulse  out  1  one-cycle pulse per denied request
- drop_cnt  out  CNT_BITS  saturating count of denied requests

Behaviour:
- Reset (async assert; release synchronous to aclk): table entries {en=0, id=0}; FSM=IDLE; req_ready=0; route_out=0; route_out_valid=0; drop_pulse=0; drop_cnt=0.
- Table write: on route_ctrl_valid, entry[route_ctrl[1:0]] <= {en=1, id=route_ctrl[9:6]}.
  - Port index >= N_DESTS: write ignored.
  - A rewrite overwrites the entry. No clear operation except reset.
  - A write becomes visible to comparisons the cycle after the strobe.
- FSM states IDLE, CHECK, SEND, DROP:
  - IDLE: req_ready=1. If req_valid, capture req_ul_id/req_port into a request register and go to CHECK.
  - CHECK: req_ready=0. Permit iff port < N_DESTS, entry.en=1 and entry.id == captured UL id.
    - Permit: load route_out, assert route_out_valid, go to SEND.
    - Deny: go to DROP.
  - SEND: hold route_out and route_out_valid stable until route_out_ready=1. On that edge deassert route_out_valid and go to IDLE.
  - DROP: drop_pulse=1 for exactly this cycle; drop_cnt increments, saturating at all-ones; go to IDLE.
- Latency: request acceptance to route_out_valid = 2 cycles. Minimum request spacing 3 cycles (req_ready high only in IDLE).
- A table write in the same cycle as CHECK on the same port: CHECK uses the pre-write value.
- route_out_valid is never withdrawn without a handshake. route_out = 0 whenever route_out_valid = 0.
- An entry rewritten while in SEND does not affect the in-flight word.
- Reset asserted mid-operation: in-flight request discarded, table cleared, no pulse or count emitted.

Decomposition:
- Shared package (lynxTypes):
  - ROUTE_W=14
  - field constants ROUTE_UL_LSB=6, ROUTE_UL_W=4, ROUTE_PORT_LSB=0, ROUTE_PORT_W=2
  - packed struct gate_cap_t {en, id[3:0]}
  - FSM state enum
- These are shared with the receive-side gate so both ends decode the same fields.
- Sub-module gate_cap_table: register array with a write port and one registered-read-compatible combinational read port. It is also reusable by the receive gate.

Test Plan:
- Reset, write route_ctrl with [9:6]=5, [1:0]=2, then request ul=5, port=2 -> route_out=0x0142 with valid 2 cycles after accept; drop_cnt=0.
- Request ul=3, port=2 against entry id 5 -> no route_out_valid; drop_pulse one cycle; drop_cnt=1.
- Request ul=0, port=1 with no entry programmed (en=0) -> denied, drop_cnt increments. Confirms en gating, since reset id is also 0.
- Permitted request with route_out_ready held 0 for 5 cycles -> route_out stable and valid throughout, req_ready=0; accepted on the ready cycle, IDLE next.
- Table write changing port 2 to id 7, same cycle as CHECK for ul=5, port 2 -> permitted (old value); next request ul=5 -> dropped.
- Assert areset during SEND -> route_out_valid and route_out drop to 0 immediately; after release the table is empty and drop_cnt=0. With CNT_BITS=2 forced, 5 denials -> drop_cnt=3.
